// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter for 2**IDX_BITS requesters. A grant is held until Done,
// withdrawal or timeout, and the next owner is chosen in the same edge.
module onehot_rr_arbiter #(
    parameter int IDX_BITS = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [(1<<IDX_BITS)-1:0]   Req,
    input  logic                       Done,
    output logic [IDX_BITS-1:0]        GrantIdx,
    output logic [(1<<IDX_BITS)-1:0]   GrantOH,
    output logic                       Busy,
    output logic                       TimeoutErr
);
    localparam int N  = 1 << IDX_BITS;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'((TIMEOUT > 0) ? TIMEOUT : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_idx;
    logic [IDX_BITS-1:0]   r_ptr;
    logic [N-1:0]          r_oh;
    logic [CW-1:0]         r_cnt;
    logic                  r_err;

    logic                  w_hit;
    logic                  w_tmo;
    logic                  w_rel;
    logic                  w_err;
    logic [IDX_BITS-1:0]   w_ptr_nxt;
    logic [IDX_BITS:0]     w_pick;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [IDX_BITS:0] f_pick(input logic [N-1:0]        req,
                                                 input logic [IDX_BITS-1:0] ptr);
        logic [IDX_BITS-1:0] idx;
        f_pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + IDX_BITS'(i);
            if (req[idx]) f_pick = {1'b1, idx};
        end
    endfunction

    function automatic logic [N-1:0] f_onehot(input logic [IDX_BITS-1:0] idx);
        f_onehot = '0;
        f_onehot[idx] = 1'b1;
    endfunction

    always_comb begin
        w_hit     = Req[r_idx];
        w_tmo     = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
        w_rel     = Done || !w_hit || w_tmo;
        // Done and withdrawal take precedence, so only a pure timeout flags an error.
        w_err     = !Done && w_hit && w_tmo;
        w_ptr_nxt = r_idx + 1'b1;
        w_pick    = f_pick(Req, (r_state == GRANT) ? w_ptr_nxt : r_ptr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_oh    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick[IDX_BITS]) begin
                        r_state <= GRANT;
                        r_idx   <= w_pick[IDX_BITS-1:0];
                        r_oh    <= f_onehot(w_pick[IDX_BITS-1:0]);
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_rel) begin
                        r_ptr <= w_ptr_nxt;
                        r_err <= w_err;
                        r_cnt <= '0;
                        // Hand over directly to the next requester with no idle bubble.
                        if (w_pick[IDX_BITS]) begin
                            r_idx <= w_pick[IDX_BITS-1:0];
                            r_oh  <= f_onehot(w_pick[IDX_BITS-1:0]);
                        end else begin
                            r_state <= IDLE;
                            r_oh    <= '0;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GrantIdx   = r_idx;
    assign GrantOH    = r_oh;
    assign Busy       = (r_state == GRANT);
    assign TimeoutErr = r_err;
endmodule
